// File: rtl/seven_segment_fun.sv
// seven_segment_fun
// Four debounced push buttons edit a 4-bit value that is shown as a hex glyph
// on one seven-segment digit. A second "spin" mode lights a single segment
// that walks around the outside of the digit instead.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   ena      in   block enable; low freezes all state except the synchronizers
//   ui_in    in   [0] inc, [1] dec, [2] mode toggle, [3] clear; [7:4] unused
//   uio_in   in   unused
//   uo_out   out  [6:0] segments {g,f,e,d,c,b,a}, [7] decimal point
//   uio_out  out  [3:0] value, [7:4] debounced buttons {btn4,btn3,btn2,btn1}
//   uio_oe   out  constant 8'hFF
//
// Optional build macro DP_BLINK_EN: when defined, the decimal point blinks
// once per divider period in NUMBER mode. When undefined it is tied to 0.
module seven_segment_fun #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int SPIN_DIV        = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int DIV_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPIN_DIV - 1);

    typedef enum logic {
        MODE_NUMBER = 1'b0,
        MODE_SPIN   = 1'b1
    } mode_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_warm;
    logic [3:0]       r_armed;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_db;
    logic [3:0]       r_dbPrev;
    logic [3:0]       r_value;
    mode_t            r_mode;
    logic [2:0]       r_spinIdx;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_uoOut;

    logic [3:0]       w_press;
    logic             w_divWrap;
    logic [6:0]       w_seg;
    logic             w_dp;
    logic             w_unused;

    assign w_unused = ^{uio_in, ui_in[7:4]};

    // Two-flop synchronizers keep sampling even while disabled. r_warm marks
    // when r_sync2 holds real pad data after reset; a button is only armed
    // once it has been seen released, so a press held through reset is
    // discarded until it is let go and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
            r_warm  <= 2'b0;
            r_armed <= 4'b0;
        end else begin
            r_sync1 <= ui_in[3:0];
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_armed <= r_armed | (~r_sync2 & {4{r_warm[1]}});
        end
    end

    // Debouncers: a differing level must persist DEBOUNCE_CYCLES samples in a
    // row; any sample matching the current debounced state restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_db     <= 4'b0;
            r_dbPrev <= 4'b0;
        end else if (ena) begin
            r_dbPrev <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle press pulse on each debounced rising edge.
    assign w_press   = r_db & ~r_dbPrev & r_armed & {4{ena}};
    assign w_divWrap = (r_div == DIV_LAST);

    // Value, mode, spin divider and spin index. Clear beats inc beats dec;
    // mode toggle is independent. Entering SPIN restarts the divider so the
    // first spin step gets a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= 4'h0;
            r_mode    <= MODE_NUMBER;
            r_spinIdx <= 3'd0;
            r_div     <= '0;
        end else if (ena) begin
            if (w_press[2] && r_mode == MODE_NUMBER) begin
                r_div <= '0;
            end else if (w_divWrap) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (w_press[3]) begin
                r_spinIdx <= 3'd0;
            end else if (r_mode == MODE_SPIN && w_divWrap) begin
                r_spinIdx <= (r_spinIdx == 3'd5) ? 3'd0 : r_spinIdx + 3'd1;
            end

            if (w_press[3]) begin
                r_value <= 4'h0;
            end else if (w_press[0]) begin
                r_value <= r_value + 4'h1;
            end else if (w_press[1]) begin
                r_value <= r_value - 4'h1;
            end

            if (w_press[2]) begin
                r_mode <= (r_mode == MODE_NUMBER) ? MODE_SPIN : MODE_NUMBER;
            end
        end
    end

`ifdef DP_BLINK_EN
    logic r_dp;

    // Decimal point blinks off the free-running divider in NUMBER mode only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp <= 1'b0;
        end else if (ena) begin
            if (r_mode == MODE_SPIN || w_press[2]) begin
                r_dp <= 1'b0;
            end else if (w_divWrap) begin
                r_dp <= ~r_dp;
            end
        end
    end

    assign w_dp = r_dp;
`else
    assign w_dp = 1'b0;
`endif

    // Segment pattern for the current mode: hex glyph or one rotating segment.
    always_comb begin
        w_seg = 7'h00;
        if (r_mode == MODE_NUMBER) begin
            case (r_value)
                4'h0: w_seg = 7'h3F;
                4'h1: w_seg = 7'h06;
                4'h2: w_seg = 7'h5B;
                4'h3: w_seg = 7'h4F;
                4'h4: w_seg = 7'h66;
                4'h5: w_seg = 7'h6D;
                4'h6: w_seg = 7'h7D;
                4'h7: w_seg = 7'h07;
                4'h8: w_seg = 7'h7F;
                4'h9: w_seg = 7'h6F;
                4'hA: w_seg = 7'h77;
                4'hB: w_seg = 7'h7C;
                4'hC: w_seg = 7'h39;
                4'hD: w_seg = 7'h5E;
                4'hE: w_seg = 7'h79;
                4'hF: w_seg = 7'h71;
                default: w_seg = 7'h00;
            endcase
        end else begin
            case (r_spinIdx)
                3'd0: w_seg = 7'h01;
                3'd1: w_seg = 7'h02;
                3'd2: w_seg = 7'h04;
                3'd3: w_seg = 7'h08;
                3'd4: w_seg = 7'h10;
                3'd5: w_seg = 7'h20;
                default: w_seg = 7'h00;
            endcase
        end
    end

    // Registered segment output; resets to the glyph for 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_uoOut <= 8'h3F;
        end else begin
            r_uoOut <= {w_dp, w_seg};
        end
    end

    assign uo_out  = r_uoOut;
    assign uio_out = {r_db, r_value};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_seven_segment_fun.sv
// Testbench for seven_segment_fun with DEBOUNCE_CYCLES=4 and SPIN_DIV=3.
// A reference model tracks the value and mode at the level of whole button
// presses and predicts the displayed glyph from the hex glyph table.
module tb_seven_segment_fun;

    localparam int DEB    = 4;
    localparam int SDIV   = 3;
    localparam int SETTLE = DEB + 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int modelValue;
    bit modelSpin;

    logic [6:0] glyphTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_segment_fun #(
        .DEBOUNCE_CYCLES(DEB),
        .SPIN_DIV       (SDIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #50 clk = ~clk;

    // Advance n clock edges, leaving time 1 unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] buttons, input int cycles);
        ui_in = {4'h0, buttons};
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Press-level model of the button actions.
    function automatic void modelPress(input logic [3:0] mask);
        if (mask[3]) modelValue = 0;
        else if (mask[0]) modelValue = (modelValue + 1) % 16;
        else if (mask[1]) modelValue = (modelValue + 15) % 16;
        if (mask[2]) modelSpin = !modelSpin;
    endfunction

    function automatic bit isSpinGlyph(input logic [7:0] seg);
        return (seg == 8'h01) || (seg == 8'h02) || (seg == 8'h04) ||
               (seg == 8'h08) || (seg == 8'h10) || (seg == 8'h20);
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, ".value"}, {4'h0, uio_out[3:0]}, 8'(modelValue));
        if (!modelSpin)
            checkOutput({tag, ".glyph"}, uo_out, {1'b0, glyphTable[modelValue]});
        else
            checkOutput({tag, ".spin"}, 8'(isSpinGlyph(uo_out)), 8'd1);
    endtask

    task automatic cleanPress(input logic [3:0] mask);
        applyStimulus(mask, SETTLE);
        checkOutput("dbState", {4'h0, uio_out[7:4]}, {4'h0, mask});
        applyStimulus(4'h0, SETTLE);
        modelPress(mask);
    endtask

    initial begin
        int n;
        int sel;
        int b;
        logic [7:0] prev;
        logic [3:0] mask;

        rst = 1'b1;
        ena = 1'b1;
        ui_in = 8'h00;
        uio_in = 8'($urandom);
        modelValue = 0;
        modelSpin = 1'b0;

        // Reset
        tick(2);
        rst = 1'b0;
        tick(1);
        checkOutput("resetUo", uo_out, 8'h3F);
        checkOutput("resetUio", uio_out, 8'h00);
        checkOutput("resetOe", uio_oe, 8'hFF);

        // Bounce on each button: toggles every cycle never settle
        for (int bi = 0; bi < 4; bi++) begin
            ui_in = 8'h00;
            for (int c = 0; c < 8; c++) begin
                ui_in[bi] = ~ui_in[bi];
                tick(1);
            end
            applyStimulus(4'h0, SETTLE);
            checkState("bounce");
            checkOutput("bounceDb", {4'h0, uio_out[7:4]}, 8'h00);
        end

        // Clean btn1 press with latency measurement
        ui_in = 8'h01;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (uio_out[3:0] != 4'h1 && n < 20);
        checkOutput("latencyRange", 8'((n - 1) >= DEB + 2 && (n - 1) <= DEB + 4), 8'd1);
        tick(1);
        checkOutput("glyphOne", uo_out, 8'h06);
        applyStimulus(4'h0, SETTLE);
        modelPress(4'h1);
        checkState("press1");

        // 15 more increments wrap to 0
        for (int i = 0; i < 15; i++) begin
            cleanPress(4'h1);
        end
        checkState("wrapUp");

        // Decrement wraps 0 -> F, clear returns to 0
        cleanPress(4'h2);
        checkState("wrapDown");
        cleanPress(4'h8);
        checkState("clear");

        // Enter SPIN mode, first glyph is segment a
        prev = uo_out;
        ui_in = 8'h04;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (uo_out == prev && n < 30);
        checkOutput("spinEnter", uo_out, 8'h01);
        modelSpin = 1'b1;
        ui_in = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            prev = uo_out;
            n = 0;
            do begin
                tick(1);
                n++;
            end while (uo_out == prev && n < 10);
            checkOutput("spinPeriod", 8'(n), 8'(SDIV));
            checkOutput("spinStep", uo_out, 8'(1 << (k % 6)));
        end
        tick(SETTLE);
        cleanPress(4'h2);
        checkOutput("spinHidesValue", {4'h0, uio_out[3:0]}, 8'(modelValue));
        cleanPress(4'h4);
        checkState("spinExit");

        // btn1 + btn4 together: clear wins
        cleanPress(4'h1);
        cleanPress(4'h1);
        checkState("preClear");
        cleanPress(4'h9);
        checkState("incAndClear");

        // Press while disabled has no effect
        ena = 1'b0;
        applyStimulus(4'h1, SETTLE);
        checkState("enaLowHold");
        applyStimulus(4'h0, SETTLE);
        ena = 1'b1;
        tick(SETTLE);
        checkState("enaLowPress");

        // Reset during a held press discards it until released
        cleanPress(4'h1);
        checkState("preReset");
        ui_in = 8'h01;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(SETTLE);
        modelValue = 0;
        modelSpin = 1'b0;
        checkState("heldThroughReset");
        applyStimulus(4'h0, SETTLE);
        checkState("releaseAfterReset");
        cleanPress(4'h1);
        checkState("pressAfterReset");

        // Randomized presses with short glitches the debouncer must reject
        for (int it = 0; it < 24; it++) begin
            b = $urandom_range(0, 3);
            ui_in = 8'h00;
            ui_in[b] = 1'b1;
            tick($urandom_range(1, DEB - 1));
            applyStimulus(4'h0, 2);
            sel = $urandom_range(0, 9);
            if (sel <= 3) mask = 4'h1;
            else if (sel <= 6) mask = 4'h2;
            else if (sel == 7) mask = 4'h8;
            else if (sel == 8) mask = 4'h4;
            else mask = 4'h3;
            cleanPress(mask);
            checkState("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_fun.md
Name: seven_segment_fun

Overview:
- Top-level user block: four debounced push buttons drive a 4-bit value shown as a hex glyph on a single seven-segment display.
- A second "spin" mode shows a single lit segment that rotates around the digit.
- Sits directly on the chip pad ring: dedicated inputs, dedicated outputs and the bidirectional IO bank.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive synchronized cycles a button must hold a new level before its debounced state changes. Minimum 2.
- SPIN_DIV, 1000000: clock cycles per spin-animation step (0.1 s at 10 MHz). Minimum 1.

Ports:
- clk  in  1  system clock, rising edge, nominal 10 MHz.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  block enable; when low, all state holds and outputs stay static.
- ui_in  in  8  [0]=btn1 inc, [1]=btn2 dec, [2]=btn3 mode toggle, [3]=btn4 clear; [7:4] unused. Buttons are active-high and asynchronous.
- uio_in  in  8  unused, ignored.
- uo_out  out  8  [6:0]=segments {g,f,e,d,c,b,a}, active-high; [7]=decimal point.
- uio_out  out  8  [3:0]=value, [7:4]=debounced button states {btn4,btn3,btn2,btn1}.
- uio_oe  out  8  constant 8'hFF (all outputs).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high, sampled on the clk rising edge.
- Reset state:
  - value=0, mode=NUMBER, spin index=0.
  - All synchronizers, debounce counters and debounced states = 0; spin divider=0.
  - uo_out=8'h3F, uio_out=8'h00.
- Per button:
  - 2-flop synchronizer feeds a debouncer with a counter of width clog2(DEBOUNCE_CYCLES)+1.
  - Synchronized level equal to the debounced state: counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced state flips and the counter clears.
  - Any glitch back to the debounced level restarts the count.
  - Rising-edge detect on the debounced state gives a 1-cycle press pulse. Releases produce no action.
- Latency: an input held steady after a transition updates value/mode no earlier than DEBOUNCE_CYCLES+2 and no later than DEBOUNCE_CYCLES+4 clk edges after the first sampling edge. Outputs are registered.
- Press actions, same cycle:
  - btn4 sets value=0 and spin index=0.
  - else btn1 sets value=value+1 mod 16 (15 wraps to 0).
  - else btn2 sets value=value-1 mod 16 (0 wraps to 15).
  - btn3 toggles mode NUMBER<->SPIN, independent of the other buttons.
  - Simultaneous presses: priority btn4 > btn1 > btn2.
- value updates in both modes; in SPIN mode the change is visible on uio_out only.
- NUMBER mode segment glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- SPIN mode:
  - The divider counts 0..SPIN_DIV-1. On wrap, spin index advances 0..5 and wraps 5->0.
  - segments = one-hot bit index (a=01, b=02, ..., f=20); g never lit.
  - On entering SPIN mode the divider clears and the index is kept.
- uo_out[7]=0 unless DP_BLINK_EN.
- ena low: synchronizers keep sampling; debounce counters, debounced states, value, mode, divider and index all freeze, and no press pulses are generated. Reset overrides ena.
- Reset asserted mid-press: the press is discarded; the button must be released and pressed again after reset.

Optional Feature:
- Macro DP_BLINK_EN.
- Defined: uo_out[7] toggles every SPIN_DIV cycles in NUMBER mode, using the same divider running freely; it is held 0 in SPIN mode and on reset.
- Undefined: uo_out[7] is constant 0 and no extra logic is built.

Test Plan (DEBOUNCE_CYCLES=4, SPIN_DIV=3, clk period 100 ns):
- Reset: rst high for 2 cycles, then low -> uo_out=8'h3F, uio_out=8'h00, uio_oe=8'hFF.
- Bounce: btn1 toggled every cycle for 8 cycles, then low -> value stays 0, uo_out stays 3F. btn2, btn3 and btn4 given the same pattern show no change either.
- Clean press: btn1 held high for 10 cycles -> value=1 and uo_out=06 within 8 cycles. 16 clean btn1 presses -> value wraps back to 0, glyph 3F.
- btn2 clean press from 0 -> value=F, uo_out=71. btn4 press -> value 0, uo_out=3F.
- btn3 press -> SPIN mode; segments step 01,02,04,08,10,20,01, changing every 3 cycles. Second btn3 press -> hex glyph of value returns.
- btn1 and btn4 pressed together -> value=0. ena low during a clean btn1 press -> no change.
